// File: rtl/branch_resolve_if.sv
// Execute-stage branch/flag bundle between the EX datapath and branch_resolve.
// Signal names follow the pipeline's EX-stage naming.
interface branch_resolve_if;
  logic        stall;
  logic        ex_valid;
  logic        ex_isZero;
  logic        ex_negative;
  logic        ex_carry;
  logic        ex_overflow;
  logic        ex_setFlags;
  logic        ex_isCBZ;
  logic        ex_isCBNZ;
  logic        ex_isBcond;
  logic        ex_isB;
  logic [3:0]  ex_cond;
  logic [63:0] ex_brTarget;
  logic [3:0]  flags;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        squash;
  logic [31:0] taken_count;

  modport master (
    output stall, ex_valid, ex_isZero, ex_negative, ex_carry, ex_overflow,
           ex_setFlags, ex_isCBZ, ex_isCBNZ, ex_isBcond, ex_isB, ex_cond, ex_brTarget,
    input  flags, redirect_valid, redirect_target, squash, taken_count
  );

  modport slave (
    input  stall, ex_valid, ex_isZero, ex_negative, ex_carry, ex_overflow,
           ex_setFlags, ex_isCBZ, ex_isCBNZ, ex_isBcond, ex_isB, ex_cond, ex_brTarget,
    output flags, redirect_valid, redirect_target, squash, taken_count
  );
endinterface

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: NZCV register, CBZ/CBNZ/B.cond/B decision,
// registered fetch redirect and wrong-path squash shadow.
module branch_resolve #(
  parameter int unsigned SHADOW_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  branch_resolve_if.slave bus
);

  localparam logic [2:0] SHADOW_LD = 3'(SHADOW_CYCLES);

  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [3:0]  r_flags;
  logic        r_redir_vld;
  logic [63:0] r_redir_tgt;
  logic [31:0] r_taken_cnt;
  logic        w_squash, w_eff, w_cond, w_taken;

  function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    // odd codes invert, except 0xF which is "always" like 0xE
    return (c[0] && c[3:1] != 3'd7) ? ~base : base;
  endfunction

  // Branch decision reads the registered flags, so a same-cycle flag-setter
  // never influences its own branch.
  always_comb begin
    w_eff   = bus.ex_valid & ~w_squash & ~bus.stall;
    w_cond  = cond_true(bus.ex_cond, r_flags);
    w_taken = w_eff & (bus.ex_isB
                     | (bus.ex_isCBZ  &  bus.ex_isZero)
                     | (bus.ex_isCBNZ & ~bus.ex_isZero)
                     | (bus.ex_isBcond &  w_cond));
  end

  // Shadow counter FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_cnt <= '0;
    else        r_cnt <= w_cnt_nxt;
  end

  // Shadow counter FSM: next state
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!bus.stall) begin
      if (r_cnt != 3'd0) w_cnt_nxt = r_cnt - 3'd1;
      else if (w_taken)  w_cnt_nxt = SHADOW_LD;
    end
  end

  // Shadow counter FSM: outputs
  always_comb begin
    w_squash = (r_cnt != 3'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags     <= '0;
      r_redir_vld <= 1'b0;
      r_redir_tgt <= '0;
      r_taken_cnt <= '0;
    end else if (!bus.stall) begin
      if (w_eff && bus.ex_setFlags)
        r_flags <= {bus.ex_negative, bus.ex_isZero, bus.ex_carry, bus.ex_overflow};
      r_redir_vld <= w_taken;
      r_redir_tgt <= w_taken ? bus.ex_brTarget : '0;
      if (w_taken && r_taken_cnt != '1)
        r_taken_cnt <= r_taken_cnt + 32'd1;
    end
  end

  assign bus.flags           = r_flags;
  assign bus.redirect_valid  = r_redir_vld;
  assign bus.redirect_target = r_redir_tgt;
  assign bus.squash          = w_squash;
  assign bus.taken_count     = r_taken_cnt;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: flag commit, branch types, shadow squash,
// stall hold, condition-code walk and asynchronous reset.
module tb_branch_resolve;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   exp_tc = 0;

  branch_resolve_if bus();

  branch_resolve #(.SHADOW_CYCLES(2)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.stall = 1'b0; bus.ex_valid = 1'b0; bus.ex_isZero = 1'b0;
    bus.ex_negative = 1'b0; bus.ex_carry = 1'b0; bus.ex_overflow = 1'b0;
    bus.ex_setFlags = 1'b0; bus.ex_isCBZ = 1'b0; bus.ex_isCBNZ = 1'b0;
    bus.ex_isBcond = 1'b0; bus.ex_isB = 1'b0; bus.ex_cond = 4'h0; bus.ex_brTarget = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  fs [4] = '{4'b0000, 4'b1001, 4'b0110, 4'b0010};
  logic [15:0] em [4] = '{16'hD6AA, 16'hD65A, 16'hE6A5, 16'hD5A6};
  logic [15:0] mask;

  initial begin
    idle();
    #12;
    chk("rst_flags", 64'(bus.flags), 64'h0);
    chk("rst_rv", 64'(bus.redirect_valid), 64'h0);
    chk("rst_tgt", bus.redirect_target, 64'h0);
    chk("rst_sq", 64'(bus.squash), 64'h0);
    chk("rst_tc", 64'(bus.taken_count), 64'h0);
    rst_n = 1'b1;
    step();

    // ADDS result 0, then B.EQ on the committed flags
    idle(); bus.ex_valid = 1; bus.ex_setFlags = 1; bus.ex_isZero = 1; bus.ex_carry = 1;
    step();
    chk("adds_flags", 64'(bus.flags), 64'h6);
    idle(); bus.ex_valid = 1; bus.ex_isBcond = 1; bus.ex_cond = 4'h0; bus.ex_brTarget = 64'h100;
    step(); exp_tc++;
    chk("beq_rv", 64'(bus.redirect_valid), 64'h1);
    chk("beq_tgt", bus.redirect_target, 64'h100);
    chk("beq_sq1", 64'(bus.squash), 64'h1);
    chk("beq_tc", 64'(bus.taken_count), 64'(exp_tc));
    idle(); step();
    chk("beq_rv_clr", 64'(bus.redirect_valid), 64'h0);
    chk("beq_sq2", 64'(bus.squash), 64'h1);
    step();
    chk("beq_sq_end", 64'(bus.squash), 64'h0);

    // CBZ not taken, CBNZ taken
    idle(); bus.ex_valid = 1; bus.ex_isCBZ = 1; bus.ex_brTarget = 64'h1000;
    step();
    chk("cbz_rv", 64'(bus.redirect_valid), 64'h0);
    chk("cbz_sq", 64'(bus.squash), 64'h0);
    idle(); bus.ex_valid = 1; bus.ex_isCBNZ = 1; bus.ex_brTarget = 64'h2000;
    step(); exp_tc++;
    chk("cbnz_rv", 64'(bus.redirect_valid), 64'h1);
    chk("cbnz_tgt", bus.redirect_target, 64'h2000);
    chk("cbnz_tc", 64'(bus.taken_count), 64'(exp_tc));
    idle(); step(); step();

    // Taken B, then ADDS and B in the shadow are ignored
    idle(); bus.ex_valid = 1; bus.ex_isB = 1; bus.ex_brTarget = 64'h3000;
    step(); exp_tc++;
    chk("b_rv", 64'(bus.redirect_valid), 64'h1);
    idle(); bus.ex_valid = 1; bus.ex_setFlags = 1; bus.ex_negative = 1; bus.ex_overflow = 1;
    step();
    chk("shadow_flags", 64'(bus.flags), 64'h6);
    chk("shadow_rv0", 64'(bus.redirect_valid), 64'h0);
    chk("shadow_sq", 64'(bus.squash), 64'h1);
    idle(); bus.ex_valid = 1; bus.ex_isB = 1; bus.ex_brTarget = 64'h4000;
    step();
    chk("shadow_rv1", 64'(bus.redirect_valid), 64'h0);
    chk("shadow_tc", 64'(bus.taken_count), 64'(exp_tc));
    chk("shadow_sq_end", 64'(bus.squash), 64'h0);

    // Taken B followed by 3 stall cycles
    idle(); bus.ex_valid = 1; bus.ex_isB = 1; bus.ex_brTarget = 64'h5000;
    step(); exp_tc++;
    chk("stl_rv0", 64'(bus.redirect_valid), 64'h1);
    for (int k = 0; k < 3; k++) begin
      idle(); bus.stall = 1; bus.ex_valid = 1; bus.ex_isB = 1; bus.ex_brTarget = 64'h6000;
      step();
      chk("stl_rv_hold", 64'(bus.redirect_valid), 64'h1);
      chk("stl_tgt_hold", bus.redirect_target, 64'h5000);
      chk("stl_sq_hold", 64'(bus.squash), 64'h1);
    end
    idle(); step();
    chk("stl_rv_clr", 64'(bus.redirect_valid), 64'h0);
    chk("stl_sq1", 64'(bus.squash), 64'h1);
    chk("stl_tc", 64'(bus.taken_count), 64'(exp_tc));
    step();
    chk("stl_sq_end", 64'(bus.squash), 64'h0);

    // setFlags + B.EQ in one instruction: branch sees old Z=1, flags take new value
    idle(); bus.ex_valid = 1; bus.ex_setFlags = 1; bus.ex_negative = 1;
    bus.ex_isBcond = 1; bus.ex_cond = 4'h0; bus.ex_brTarget = 64'h9000;
    step(); exp_tc++;
    chk("combo_flags", 64'(bus.flags), 64'h8);
    chk("combo_rv", 64'(bus.redirect_valid), 64'h1);
    idle(); step(); step();

    // Walk all condition codes over four flag settings
    for (int s = 0; s < 4; s++) begin
      idle(); bus.ex_valid = 1; bus.ex_setFlags = 1;
      bus.ex_negative = fs[s][3]; bus.ex_isZero = fs[s][2];
      bus.ex_carry = fs[s][1]; bus.ex_overflow = fs[s][0];
      step();
      chk("walk_flags", 64'(bus.flags), 64'(fs[s]));
      mask = em[s];
      for (int c = 0; c < 16; c++) begin
        idle(); bus.ex_valid = 1; bus.ex_isBcond = 1; bus.ex_cond = 4'(c);
        bus.ex_brTarget = 64'(32'h100 + c);
        step();
        chk($sformatf("cond_f%0h_c%0h", fs[s], c), 64'(bus.redirect_valid), 64'(mask[c]));
        if (mask[c]) begin
          exp_tc++;
          idle(); step(); step();
        end
      end
    end
    idle();
    chk("walk_tc", 64'(bus.taken_count), 64'(exp_tc));

    // Async reset mid-shadow with redirect pending
    bus.ex_valid = 1; bus.ex_isB = 1; bus.ex_brTarget = 64'h7000;
    step();
    chk("pre_rst_rv", 64'(bus.redirect_valid), 64'h1);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_flags", 64'(bus.flags), 64'h0);
    chk("arst_rv", 64'(bus.redirect_valid), 64'h0);
    chk("arst_tgt", bus.redirect_target, 64'h0);
    chk("arst_sq", 64'(bus.squash), 64'h0);
    chk("arst_tc", 64'(bus.taken_count), 64'h0);
    #3 rst_n = 1'b1;
    step();
    bus.ex_valid = 1; bus.ex_isCBZ = 1; bus.ex_isZero = 1; bus.ex_brTarget = 64'h8000;
    step();
    chk("post_rst_rv", 64'(bus.redirect_valid), 64'h1);
    chk("post_rst_tgt", bus.redirect_target, 64'h8000);
    chk("post_rst_tc", 64'(bus.taken_count), 64'h1);
    chk("post_rst_sq", 64'(bus.squash), 64'h1);
    idle(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/branch_resolve.md
# branch_resolve

Execute-stage branch resolution and condition-flag unit for the pipelined ARM core. Consumes the ALU's 64-bit zero-detect result and N/C/V outputs, holds the architectural NZCV flag register, and resolves CBZ/CBNZ/B.cond/B. On a taken branch it issues a registered fetch redirect and squashes the wrong-path instructions that follow through EX. It sits directly downstream of the ALU zero detector and feeds the IF redirect mux and the EX/MEM write-enable gating.

## Interface
- SHADOW_CYCLES, 2, number of EX cycles squashed after a taken branch (1–7)
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  pipeline stall; freezes all state in this block
- ex_valid  in  1  instruction in EX is real (not a bubble)
- ex_isZero  in  1  zero-detect of current ALU result
- ex_negative, ex_carry, ex_overflow  in  1 each  ALU N/C/V outputs
- ex_setFlags  in  1  instruction writes NZCV (ADDS/SUBS)
- ex_isCBZ, ex_isCBNZ, ex_isBcond, ex_isB  in  1 each  one-hot branch type (at most one high)
- ex_cond  in  4  B.cond condition code
- ex_brTarget  in  64  computed branch target address
- flags  out  4  NZCV register {N,Z,C,V}
- redirect_valid  out  1  fetch must load redirect_target
- redirect_target  out  64  registered target address
- squash  out  1  current EX instruction is wrong-path; suppress its writes
- taken_count  out  32  saturating count of taken branches

## Operation
- Effective instruction: ex_valid & ~squash & ~stall. Non-effective cycles change nothing except redirect_valid clearing and shadow decrement, as below.
- Flag update: effective & ex_setFlags -> flags <= {ex_negative, ex_isZero, ex_carry, ex_overflow} at clock edge.
- Taken decision (combinational, effective only): ex_isB -> 1; ex_isCBZ -> ex_isZero; ex_isCBNZ -> ~ex_isZero; ex_isBcond -> cond_true(ex_cond, flags register value).
- B.cond always uses the registered flags, never same-cycle ALU flags. A flag-setter immediately preceding B.cond has already committed.
- cond_true: 0 EQ Z; 1 NE ~Z; 2 HS C; 3 LO ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V; 8 HI C&~Z; 9 LS ~(C&~Z); A GE N==V; B LT N!=V; C GT ~Z&(N==V); D LE ~(~Z&(N==V)); E, F always.
- State machine (3-bit shadow counter cnt):
  - RUN (cnt=0): squash=0. A taken branch loads cnt<=SHADOW_CYCLES, redirect_valid<=1, redirect_target<=ex_brTarget, taken_count+1 (saturate at 0xFFFFFFFF).
  - SHADOW (cnt>0): squash=1. Each non-stalled cycle cnt<=cnt-1, then back to RUN at 0. Branches and setFlags in EX are ignored.
- squash is combinational from cnt only (cnt!=0).
- redirect_valid is high for exactly one non-stalled cycle. Under stall it and redirect_target hold until the first non-stalled edge, then clear.
- Same instruction with setFlags and a branch: flags update, and branch evaluation uses the pre-update flags.

## Timing
- Reset (async, reset=0): flags=0000, redirect_valid=0, redirect_target=0, cnt=0 (squash=0), taken_count=0. Takes effect immediately and aborts any redirect or shadow in progress.
- Branch effective in EX at cycle T -> redirect_valid=1 and redirect_target valid in T+1. squash=1 for cycles T+1..T+SHADOW_CYCLES, with no stall.
- Flag write at edge ending cycle T -> visible on flags and to B.cond in T+1.
- Stall cycles add no latency beyond their own duration. Counter and flags are frozen while stall=1.
- Bubbles (ex_valid=0) in RUN produce no effect. Bubbles in SHADOW still consume shadow cycles.

## Test plan
- ADDS producing 0 (isZero=1, N=0, C=1, V=0) then B.cond EQ next cycle -> flags=0110, redirect_valid=1 one cycle later with target 0x100, squash high for 2 cycles.
- CBZ with isZero=0, then CBNZ with isZero=0, target 0x2000 -> first not taken (no redirect), second redirect_target=0x2000, taken_count=1.
- Taken B at T, ADDS and B at T+1/T+2 (squashed) -> flags unchanged, no second redirect, taken_count=1, squash clears at T+3.
- Taken branch then stall=1 for 3 cycles -> redirect_valid held 3 cycles then one more, cnt frozen, squash ends SHADOW_CYCLES non-stalled cycles later.
- Walk all 16 ex_cond values against flags 0000, 1001, 0110, 0010 -> taken matches cond_true table, AL/NV always taken.
- Assert reset=0 asynchronously mid-shadow with redirect_valid=1 -> all outputs zero immediately, and the next branch after release resolves normally.
